// File: rtl/ram0_arb_pkg.sv
// Shared types and constants for the ram0 SRAM arbiter.
package ram0_arb_pkg;

    localparam int unsigned ACCESS_CYCLES_DEF = 4;
    localparam int unsigned WR_DELAY_DEF      = 2;
    localparam int unsigned CNT_W             = 4;
    localparam int unsigned ADDR_W            = 24;
    localparam int unsigned DATA_W            = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SRD      = 3'd1,
        ST_SWR_WAIT = 3'd2,
        ST_SWR      = 3'd3,
        ST_MRD      = 3'd4,
        ST_MWR      = 3'd5
    } arb_state_e;

    typedef struct packed {
        logic              valid;
        logic              wr;
        logic [ADDR_W-1:0] addr;
    } snes_req_t;

    typedef struct packed {
        logic              valid;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mcu_req_t;

    function automatic logic is_read_state(arb_state_e s);
        return (s == ST_SRD) || (s == ST_MRD);
    endfunction

    function automatic logic is_write_state(arb_state_e s);
        return (s == ST_SWR) || (s == ST_MWR);
    endfunction

endpackage

// File: rtl/ram0_arbiter_if.sv
// SNES, MCU and SRAM signal bundle of the ram0 arbiter.
interface ram0_arbiter_if;
    import ram0_arb_pkg::*;

    logic              SNES_RD;
    logic              SNES_WR;
    logic [DATA_W-1:0] SNES_DATA;
    logic              ram0_enable;
    logic [ADDR_W-1:0] ram0_addr;
    logic [DATA_W-1:0] snes_rddata;

    logic              mcu_rrq;
    logic              mcu_wrq;
    logic [ADDR_W-1:0] mcu_addr;
    logic [DATA_W-1:0] mcu_wrdata;
    logic [DATA_W-1:0] mcu_rddata;
    logic              mcu_rdy;
    logic              mcu_done;

    logic [ADDR_W-1:0] RAM_ADDR;
    logic [DATA_W-1:0] RAM_DATA_OUT;
    logic              RAM_DATA_OE;
    logic              RAM_OE;
    logic              RAM_WE;
    logic [DATA_W-1:0] RAM_DATA_IN;

    modport slave (
        input  SNES_RD, SNES_WR, SNES_DATA, ram0_enable, ram0_addr,
        input  mcu_rrq, mcu_wrq, mcu_addr, mcu_wrdata, RAM_DATA_IN,
        output snes_rddata, mcu_rddata, mcu_rdy, mcu_done,
        output RAM_ADDR, RAM_DATA_OUT, RAM_DATA_OE, RAM_OE, RAM_WE
    );

    modport master (
        output SNES_RD, SNES_WR, SNES_DATA, ram0_enable, ram0_addr,
        output mcu_rrq, mcu_wrq, mcu_addr, mcu_wrdata, RAM_DATA_IN,
        input  snes_rddata, mcu_rddata, mcu_rdy, mcu_done,
        input  RAM_ADDR, RAM_DATA_OUT, RAM_DATA_OE, RAM_OE, RAM_WE
    );

endinterface

// File: rtl/edge_sync.sv
// Three-flop synchroniser for an asynchronous active-low strobe with a
// registered one-cycle falling-edge pulse.
module edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic fall_q
);

    logic [2:0] sr_q, sr_d;
    logic       fall_d;

    always_comb begin
        sr_d   = {sr_q[1:0], async_in};
        fall_d = (sr_q[2:1] == 2'b10);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q   <= '1;
            fall_q <= 1'b0;
        end else begin
            sr_q   <= sr_d;
            fall_q <= fall_d;
        end
    end

endmodule

// File: rtl/ram0_arbiter.sv
// Shares the ram0 SRAM between SNES bus cycles (always first) and MCU
// requests using fixed-length, fully registered access cycles.
module ram0_arbiter
    import ram0_arb_pkg::*;
#(
    parameter int unsigned ACCESS_CYCLES = ACCESS_CYCLES_DEF,
    parameter int unsigned WR_DELAY      = WR_DELAY_DEF
) (
    input logic          CLK,
    input logic          RST,
    ram0_arbiter_if.slave bus
);

    localparam logic [CNT_W-1:0] ACC_LOAD = CNT_W'(ACCESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] WR_LOAD  = CNT_W'(WR_DELAY - 1);

    logic rd_fall, wr_fall;

    arb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    snes_req_t         snes_pend_q, snes_pend_d;
    mcu_req_t          mcu_pend_q, mcu_pend_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_data_out_q, ram_data_out_d;
    logic              ram_data_oe_q, ram_data_oe_d;
    logic              ram_oe_q, ram_oe_d;
    logic              ram_we_q, ram_we_d;
    logic [DATA_W-1:0] snes_rddata_q, snes_rddata_d;
    logic [DATA_W-1:0] mcu_rddata_q, mcu_rddata_d;
    logic              mcu_rdy_q, mcu_rdy_d;
    logic              mcu_done_q, mcu_done_d;

    snes_req_t         snes_new_c;
    snes_req_t         snes_sel_c;

    edge_sync u_rd_sync (
        .clk      (CLK),
        .rst      (RST),
        .async_in (bus.SNES_RD),
        .fall_q   (rd_fall)
    );

    edge_sync u_wr_sync (
        .clk      (CLK),
        .rst      (RST),
        .async_in (bus.SNES_WR),
        .fall_q   (wr_fall)
    );

    // A detected edge only becomes a request when the decoder qualifies it.
    always_comb begin
        snes_new_c.valid = (rd_fall | wr_fall) & bus.ram0_enable;
        snes_new_c.wr    = ~rd_fall;
        snes_new_c.addr  = bus.ram0_addr;
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        snes_pend_d    = snes_pend_q;
        mcu_pend_d     = mcu_pend_q;
        ram_addr_d     = ram_addr_q;
        ram_data_out_d = ram_data_out_q;
        snes_rddata_d  = snes_rddata_q;
        mcu_rddata_d   = mcu_rddata_q;
        mcu_rdy_d      = mcu_rdy_q;
        mcu_done_d     = 1'b0;
        snes_sel_c     = '0;

        if (mcu_rdy_q && (bus.mcu_rrq || bus.mcu_wrq)) begin
            mcu_pend_d.valid = 1'b1;
            mcu_pend_d.wr    = ~bus.mcu_rrq;
            mcu_pend_d.addr  = bus.mcu_addr;
            mcu_pend_d.wdata = bus.mcu_wrdata;
            mcu_rdy_d        = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                // A fresh edge supersedes an older pending one.
                snes_sel_c = snes_new_c.valid ? snes_new_c : snes_pend_q;
                if (snes_sel_c.valid) begin
                    snes_pend_d = '0;
                    ram_addr_d  = snes_sel_c.addr;
                    if (snes_sel_c.wr) begin
                        state_d = ST_SWR_WAIT;
                        cnt_d   = WR_LOAD;
                    end else begin
                        state_d = ST_SRD;
                        cnt_d   = ACC_LOAD;
                    end
                end else if (mcu_pend_q.valid) begin
                    mcu_pend_d.valid = 1'b0;
                    ram_addr_d       = mcu_pend_q.addr;
                    cnt_d            = ACC_LOAD;
                    if (mcu_pend_q.wr) begin
                        state_d        = ST_MWR;
                        ram_data_out_d = mcu_pend_q.wdata;
                    end else begin
                        state_d = ST_MRD;
                    end
                end
            end

            ST_SWR_WAIT: begin
                if (snes_new_c.valid) begin
                    snes_pend_d = snes_new_c;
                end
                if (cnt_q == '0) begin
                    state_d        = ST_SWR;
                    cnt_d          = ACC_LOAD;
                    ram_data_out_d = bus.SNES_DATA;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            ST_SRD, ST_SWR, ST_MRD, ST_MWR: begin
                if (snes_new_c.valid) begin
                    snes_pend_d = snes_new_c;
                end
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    if (state_q == ST_SRD) begin
                        snes_rddata_d = bus.RAM_DATA_IN;
                    end
                    if (state_q == ST_MRD) begin
                        mcu_rddata_d = bus.RAM_DATA_IN;
                    end
                    if ((state_q == ST_MRD) || (state_q == ST_MWR)) begin
                        mcu_done_d = 1'b1;
                        mcu_rdy_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Strobes follow the next state so they are registered with it.
        ram_oe_d      = ~is_read_state(state_d);
        ram_we_d      = ~is_write_state(state_d);
        ram_data_oe_d = is_write_state(state_d);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            snes_pend_q    <= '0;
            mcu_pend_q     <= '0;
            ram_addr_q     <= '0;
            ram_data_out_q <= '0;
            ram_data_oe_q  <= 1'b0;
            ram_oe_q       <= 1'b1;
            ram_we_q       <= 1'b1;
            snes_rddata_q  <= '0;
            mcu_rddata_q   <= '0;
            mcu_rdy_q      <= 1'b1;
            mcu_done_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            snes_pend_q    <= snes_pend_d;
            mcu_pend_q     <= mcu_pend_d;
            ram_addr_q     <= ram_addr_d;
            ram_data_out_q <= ram_data_out_d;
            ram_data_oe_q  <= ram_data_oe_d;
            ram_oe_q       <= ram_oe_d;
            ram_we_q       <= ram_we_d;
            snes_rddata_q  <= snes_rddata_d;
            mcu_rddata_q   <= mcu_rddata_d;
            mcu_rdy_q      <= mcu_rdy_d;
            mcu_done_q     <= mcu_done_d;
        end
    end

    assign bus.RAM_ADDR     = ram_addr_q;
    assign bus.RAM_DATA_OUT = ram_data_out_q;
    assign bus.RAM_DATA_OE  = ram_data_oe_q;
    assign bus.RAM_OE       = ram_oe_q;
    assign bus.RAM_WE       = ram_we_q;
    assign bus.snes_rddata  = snes_rddata_q;
    assign bus.mcu_rddata   = mcu_rddata_q;
    assign bus.mcu_rdy      = mcu_rdy_q;
    assign bus.mcu_done     = mcu_done_q;

endmodule

// File: tb/tb_ram0_arbiter.sv
// Directed bench for ram0_arbiter: SNES/MCU accesses, collision, reset.
module tb_ram0_arbiter;
    import ram0_arb_pkg::*;

    logic CLK;
    logic RST;
    int   n_checks;
    int   n_fail;

    ram0_arbiter_if bus ();

    ram0_arbiter dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // SRAM read model: fixed contents, bus idles at zero while /OE is high.
    always_comb begin
        if (bus.RAM_OE) begin
            bus.RAM_DATA_IN = 8'h00;
        end else begin
            case (bus.RAM_ADDR)
                24'h000123: bus.RAM_DATA_IN = 8'h5A;
                24'h020040: bus.RAM_DATA_IN = 8'h3C;
                24'h000011: bus.RAM_DATA_IN = 8'hEE;
                default:    bus.RAM_DATA_IN = 8'hFF;
            endcase
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (3) step();
        n_checks++; if (bus.RAM_OE !== 1'b1) begin n_fail++; $display("FAIL reset_ram_oe got %b exp 1", bus.RAM_OE); end
        n_checks++; if (bus.RAM_WE !== 1'b1) begin n_fail++; $display("FAIL reset_ram_we got %b exp 1", bus.RAM_WE); end
        n_checks++; if (bus.RAM_DATA_OE !== 1'b0) begin n_fail++; $display("FAIL reset_data_oe got %b exp 0", bus.RAM_DATA_OE); end
        n_checks++; if (bus.RAM_ADDR !== 24'h0) begin n_fail++; $display("FAIL reset_addr got %h exp 0", bus.RAM_ADDR); end
        n_checks++; if (bus.RAM_DATA_OUT !== 8'h0) begin n_fail++; $display("FAIL reset_data_out got %h exp 0", bus.RAM_DATA_OUT); end
        n_checks++; if (bus.snes_rddata !== 8'h0) begin n_fail++; $display("FAIL reset_snes_rddata got %h exp 0", bus.snes_rddata); end
        n_checks++; if (bus.mcu_rddata !== 8'h0) begin n_fail++; $display("FAIL reset_mcu_rddata got %h exp 0", bus.mcu_rddata); end
        n_checks++; if (bus.mcu_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_mcu_rdy got %b exp 1", bus.mcu_rdy); end
        n_checks++; if (bus.mcu_done !== 1'b0) begin n_fail++; $display("FAIL reset_mcu_done got %b exp 0", bus.mcu_done); end
        RST = 1'b0;
        step();
    endtask

    task automatic test_snes_read();
        logic exp_oe;
        bus.ram0_enable = 1'b1;
        bus.ram0_addr   = 24'h000123;
        bus.SNES_RD     = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            exp_oe = (k >= 4 && k <= 7) ? 1'b0 : 1'b1;
            n_checks++; if (bus.RAM_OE !== exp_oe) begin n_fail++; $display("FAIL srd_oe k=%0d got %b exp %b", k, bus.RAM_OE, exp_oe); end
            n_checks++; if (bus.RAM_WE !== 1'b1 || bus.mcu_done !== 1'b0 || bus.mcu_rdy !== 1'b1) begin
                n_fail++; $display("FAIL srd_quiet k=%0d we=%b done=%b rdy=%b exp 1,0,1", k, bus.RAM_WE, bus.mcu_done, bus.mcu_rdy);
            end
            if (!exp_oe) begin
                n_checks++; if (bus.RAM_ADDR !== 24'h000123) begin n_fail++; $display("FAIL srd_addr k=%0d got %h exp 000123", k, bus.RAM_ADDR); end
            end
            if (k == 7) begin
                n_checks++; if (bus.snes_rddata !== 8'h00) begin n_fail++; $display("FAIL srd_early_data got %h exp 00", bus.snes_rddata); end
            end
            if (k == 8) begin
                n_checks++; if (bus.snes_rddata !== 8'h5A) begin n_fail++; $display("FAIL srd_data got %h exp 5a", bus.snes_rddata); end
            end
        end
        bus.SNES_RD = 1'b1;
        repeat (5) step();
    endtask

    task automatic test_mcu_write();
        logic exp_we;
        bus.mcu_wrq    = 1'b1;
        bus.mcu_addr   = 24'h010000;
        bus.mcu_wrdata = 8'hC3;
        step();
        bus.mcu_wrq = 1'b0;
        n_checks++; if (bus.mcu_rdy !== 1'b0) begin n_fail++; $display("FAIL mwr_rdy_drop got %b exp 0", bus.mcu_rdy); end
        for (int k = 1; k <= 6; k++) begin
            if (k == 2) begin
                bus.mcu_rrq  = 1'b1;
                bus.mcu_addr = 24'h020040;
            end
            step();
            if (k == 3) bus.mcu_rrq = 1'b0;
            exp_we = (k <= 4) ? 1'b0 : 1'b1;
            n_checks++; if (bus.RAM_WE !== exp_we || bus.RAM_DATA_OE !== ~exp_we) begin
                n_fail++; $display("FAIL mwr_we k=%0d got we=%b doe=%b exp we=%b", k, bus.RAM_WE, bus.RAM_DATA_OE, exp_we);
            end
            if (!exp_we) begin
                n_checks++; if (bus.RAM_DATA_OUT !== 8'hC3 || bus.RAM_ADDR !== 24'h010000) begin
                    n_fail++; $display("FAIL mwr_bus k=%0d got %h@%h exp c3@010000", k, bus.RAM_DATA_OUT, bus.RAM_ADDR);
                end
            end
            n_checks++; if (bus.mcu_done !== (k == 5)) begin n_fail++; $display("FAIL mwr_done k=%0d got %b exp %b", k, bus.mcu_done, (k == 5)); end
            n_checks++; if (bus.mcu_rdy !== (k >= 5)) begin n_fail++; $display("FAIL mwr_rdy k=%0d got %b exp %b", k, bus.mcu_rdy, (k >= 5)); end
        end
        // The read issued while busy must have been dropped.
        for (int k = 0; k < 4; k++) begin
            step();
            n_checks++; if (bus.RAM_OE !== 1'b1 || bus.mcu_done !== 1'b0) begin
                n_fail++; $display("FAIL mwr_ignored_req k=%0d oe=%b done=%b exp 1,0", k, bus.RAM_OE, bus.mcu_done);
            end
        end
    endtask

    task automatic test_collision();
        logic exp_oe;
        bus.ram0_enable = 1'b1;
        bus.ram0_addr   = 24'h000011;
        bus.SNES_RD     = 1'b0;
        bus.mcu_rrq     = 1'b1;
        bus.mcu_addr    = 24'h020040;
        for (int k = 1; k <= 12; k++) begin
            step();
            bus.mcu_rrq = 1'b0;
            exp_oe = ((k >= 2 && k <= 5) || (k >= 7 && k <= 10)) ? 1'b0 : 1'b1;
            n_checks++; if (bus.RAM_OE !== exp_oe || bus.RAM_WE !== 1'b1) begin
                n_fail++; $display("FAIL col_oe k=%0d got oe=%b we=%b exp oe=%b we=1", k, bus.RAM_OE, bus.RAM_WE, exp_oe);
            end
            if (k >= 2 && k <= 5) begin
                n_checks++; if (bus.RAM_ADDR !== 24'h020040) begin n_fail++; $display("FAIL col_mcu_addr k=%0d got %h exp 020040", k, bus.RAM_ADDR); end
            end
            if (k >= 7 && k <= 10) begin
                n_checks++; if (bus.RAM_ADDR !== 24'h000011) begin n_fail++; $display("FAIL col_snes_addr k=%0d got %h exp 000011", k, bus.RAM_ADDR); end
            end
            n_checks++; if (bus.mcu_done !== (k == 6)) begin n_fail++; $display("FAIL col_done k=%0d got %b exp %b", k, bus.mcu_done, (k == 6)); end
            if (k == 6) begin
                n_checks++; if (bus.mcu_rddata !== 8'h3C) begin n_fail++; $display("FAIL col_mcu_data got %h exp 3c", bus.mcu_rddata); end
            end
            if (k == 10) begin
                n_checks++; if (bus.snes_rddata !== 8'h5A) begin n_fail++; $display("FAIL col_snes_early got %h exp 5a", bus.snes_rddata); end
            end
            if (k == 11) begin
                n_checks++; if (bus.snes_rddata !== 8'hEE) begin n_fail++; $display("FAIL col_snes_data got %h exp ee", bus.snes_rddata); end
            end
        end
        bus.SNES_RD = 1'b1;
        repeat (5) step();
    endtask

    task automatic test_unqualified();
        bus.ram0_enable = 1'b0;
        bus.ram0_addr   = 24'h000123;
        for (int k = 0; k < 20; k++) begin
            bus.SNES_RD = ((k % 8) < 4) ? 1'b0 : 1'b1;
            bus.SNES_WR = ((k % 10) >= 2 && (k % 10) < 5) ? 1'b0 : 1'b1;
            step();
            n_checks++; if (bus.RAM_OE !== 1'b1 || bus.RAM_WE !== 1'b1) begin
                n_fail++; $display("FAIL unq_strobes k=%0d oe=%b we=%b exp 1,1", k, bus.RAM_OE, bus.RAM_WE);
            end
            n_checks++; if (dut.state_q !== ST_IDLE) begin n_fail++; $display("FAIL unq_state k=%0d got %0d exp 0", k, dut.state_q); end
        end
        bus.SNES_RD = 1'b1;
        bus.SNES_WR = 1'b1;
        repeat (6) step();
    endtask

    task automatic test_snes_write();
        logic exp_we;
        bus.ram0_enable = 1'b1;
        bus.ram0_addr   = 24'h000300;
        bus.SNES_DATA   = 8'h77;
        bus.SNES_WR     = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            step();
            exp_we = (k >= 6 && k <= 9) ? 1'b0 : 1'b1;
            n_checks++; if (bus.RAM_WE !== exp_we || bus.RAM_DATA_OE !== ~exp_we || bus.RAM_OE !== 1'b1) begin
                n_fail++; $display("FAIL swr_strobe k=%0d we=%b doe=%b oe=%b exp we=%b", k, bus.RAM_WE, bus.RAM_DATA_OE, bus.RAM_OE, exp_we);
            end
            if (!exp_we) begin
                n_checks++; if (bus.RAM_DATA_OUT !== 8'h77 || bus.RAM_ADDR !== 24'h000300) begin
                    n_fail++; $display("FAIL swr_bus k=%0d got %h@%h exp 77@000300", k, bus.RAM_DATA_OUT, bus.RAM_ADDR);
                end
            end
        end
        bus.SNES_WR = 1'b1;
        repeat (5) step();
    endtask

    task automatic test_reset_mid_access();
        bus.mcu_wrq    = 1'b1;
        bus.mcu_addr   = 24'h010000;
        bus.mcu_wrdata = 8'h99;
        step();
        bus.mcu_wrq = 1'b0;
        step();
        step();
        n_checks++; if (dut.cnt_q !== 4'd2 || bus.RAM_WE !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_setup cnt=%0d we=%b exp 2,0", dut.cnt_q, bus.RAM_WE);
        end
        RST = 1'b1;
        step();
        RST = 1'b0;
        n_checks++; if (bus.RAM_WE !== 1'b1 || bus.RAM_OE !== 1'b1 || bus.RAM_DATA_OE !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_strobes we=%b oe=%b doe=%b exp 1,1,0", bus.RAM_WE, bus.RAM_OE, bus.RAM_DATA_OE);
        end
        n_checks++; if (bus.mcu_rdy !== 1'b1) begin n_fail++; $display("FAIL rst_mid_rdy got %b exp 1", bus.mcu_rdy); end
        for (int k = 0; k < 4; k++) begin
            step();
            n_checks++; if (bus.mcu_done !== 1'b0 || bus.RAM_WE !== 1'b1) begin
                n_fail++; $display("FAIL rst_mid_no_done k=%0d done=%b we=%b exp 0,1", k, bus.mcu_done, bus.RAM_WE);
            end
        end
        // Both request strobes together: the read takes precedence.
        bus.mcu_rrq    = 1'b1;
        bus.mcu_wrq    = 1'b1;
        bus.mcu_addr   = 24'h020040;
        bus.mcu_wrdata = 8'h11;
        step();
        bus.mcu_rrq = 1'b0;
        bus.mcu_wrq = 1'b0;
        n_checks++; if (bus.mcu_rdy !== 1'b0) begin n_fail++; $display("FAIL post_rst_accept rdy=%b exp 0", bus.mcu_rdy); end
        for (int k = 1; k <= 5; k++) begin
            step();
            n_checks++; if (bus.RAM_OE !== (k == 5) || bus.RAM_WE !== 1'b1) begin
                n_fail++; $display("FAIL post_rst_rd k=%0d oe=%b we=%b exp oe=%b we=1", k, bus.RAM_OE, bus.RAM_WE, (k == 5));
            end
            n_checks++; if (bus.mcu_done !== (k == 5)) begin n_fail++; $display("FAIL post_rst_done k=%0d got %b exp %b", k, bus.mcu_done, (k == 5)); end
        end
        n_checks++; if (bus.mcu_rddata !== 8'h3C) begin n_fail++; $display("FAIL post_rst_data got %h exp 3c", bus.mcu_rddata); end
    endtask

    initial begin
        n_checks        = 0;
        n_fail          = 0;
        RST             = 1'b1;
        bus.SNES_RD     = 1'b1;
        bus.SNES_WR     = 1'b1;
        bus.SNES_DATA   = 8'h00;
        bus.ram0_enable = 1'b0;
        bus.ram0_addr   = 24'h0;
        bus.mcu_rrq     = 1'b0;
        bus.mcu_wrq     = 1'b0;
        bus.mcu_addr    = 24'h0;
        bus.mcu_wrdata  = 8'h0;

        test_reset();
        test_snes_read();
        test_mcu_write();
        test_collision();
        test_unqualified();
        test_snes_write();
        test_reset_mid_access();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
